decode_stage: RTL
=================

# decode_stage

Registered Thumb instruction-decode stage with valid/ready handshakes on both sides, sitting between the fetch unit and the register-read/execute stage. It decodes one 16-bit halfword per accepted transfer into register addresses, a sign/zero-extended immediate, an operation code and a condition field. Optionally, it assembles the two-halfword BL instruction through a small state machine. Flush support discards in-flight work on branches.

## Interface
- `IMM_W`, 32: width of decoded immediate (≥ 24).
- `PC_W`, 32: width of the instruction-address tag carried alongside each instruction.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset; synchronous, active-low.
- `i_flush`  in  1: discard held output and partial BL state.
- `i_valid`  in  1: `i_ir`/`i_pc` valid.
- `o_ready`  out  1: stage accepts a halfword this cycle.
- `i_ir`  in  16: instruction halfword.
- `i_pc`  in  PC_W: address of `i_ir`.
- `o_valid`  out  1: decoded outputs valid.
- `i_ready`  in  1: downstream accepts outputs.
- `o_op`  out  4: operation code.
- `o_addrrn`, `o_addrrt`, `o_addrrd`  out  4 each: register addresses.
- `o_imm`  out  IMM_W: decoded immediate.
- `o_cond`  out  4: condition (B<c> only, else 4'hE).
- `o_pc`  out  PC_W: address of the (first halfword of the) instruction.

## Operation
- Op codes:
  - 0 NOP, 1 ADD_IMM3, 2 SUB_SP, 3 MOV_IMM, 4 MOV_REG, 5 LDR_IMM, 6 LDR_LIT, 7 STR_IMM, 8 B, 9 BCOND, 10 CMP_IMM, 11 BL, 15 ILLEGAL.
- Decode on `i_ir[15:7]`:
  - 0001110??: ADD_IMM3. rn=[5:3], rd=[2:0], imm=zext([8:6]).
  - 101100001: SUB_SP. rn=rd=13, imm=zext({[6:0],2'b00}).
  - 00100????: MOV_IMM. rd=[10:8], imm=zext([7:0]).
  - 01000110?: MOV_REG. rn=[6:3], rd={[7],[2:0]}, imm=0.
  - 01101????: LDR_IMM. rn=[5:3], rt=[2:0], imm=zext({[10:6],2'b00}).
  - 01001????: LDR_LIT. rn=15, rt=[10:8], imm=zext({[7:0],2'b00}).
  - 01100????: STR_IMM. rn=[5:3], rt=[2:0], imm=zext({[10:6],2'b00}).
  - 11100????: B. rn=15, imm=sext({[10:0],1'b0}).
  - 1101?????: if cond [11:8]=1110 or 1111, ILLEGAL; otherwise BCOND. rn=15, cond=[11:8], imm=sext({[7:0],1'b0}).
  - 00101????: CMP_IMM. rn=[10:8], imm=zext([7:0]).
  - Anything else: ILLEGAL.
- Unused address fields are 0, and unused imm is 0.
- FSM (with `DECODE_BL_EN`):
  - IDLE: an accepted halfword with [15:11]=11110 stores [10:0] in the hi register and `i_pc` in the pc register, produces no output, and moves to WAIT_LO.
  - WAIT_LO, accepted halfword [15:11]=11111: emit BL with rd=14, imm=sext({hi[10:0],ir[10:0],1'b0}), o_pc=stored pc; go to IDLE.
  - WAIT_LO, any other halfword: emit ILLEGAL with o_pc=stored pc, imm=0; go to IDLE. That halfword is consumed, not re-decoded.
  - IDLE, lone 11111 halfword: ILLEGAL.
- Handshake:
  - `o_ready = !o_valid || i_ready`, forced 0 while `i_flush`=1.
  - A transfer happens when `i_valid && o_ready`.
  - Outputs hold stable while `o_valid && !i_ready`.
- Flush:
  - Same-cycle priority over everything.
  - Next cycle: `o_valid`=0, FSM=IDLE.
  - The input presented during flush is not accepted.

## Timing
- Latency is 1 cycle: a halfword accepted at edge N appears on outputs after edge N, for non-prefix instructions.
- BL: output appears after the edge accepting the second halfword.
- Throughput is 1 instruction/cycle when `i_ready`=1; a simultaneous output drain and input accept is permitted.
- Reset (`rst`=0 at an edge): `o_valid`=0, `o_op`=0, all addresses=0, `o_imm`=0, `o_cond`=4'hE, `o_pc`=0, FSM=IDLE, hi/pc registers=0.
- Reset asserted mid-BL drops the prefix.
- `o_ready` is combinational from `o_valid`, `i_ready` and `i_flush` only.

## Configuration
- `DECODE_BL_EN` defined: the BL FSM, hi register and pc register are present, as above.
- `DECODE_BL_EN` undefined: no FSM or extra registers; the 11110 and 11111 halfwords each decode immediately as ILLEGAL with 1-cycle latency.

## Test plan
- Reset, then `i_ir`=16'h1C88 (ADD r0,r1,#2) with `i_pc`=0x100 -> next cycle: o_valid=1, op=1, rn=1, rd=0, imm=2, o_pc=0x100.
- B<c> `i_ir`=16'hD0FE -> op=9, cond=0, imm=0xFFFFFFFC. Then `i_ir`=16'hDE00 -> op=15.
- Backpressure: `i_ready`=0 for 3 cycles after an LDR 16'h6848 -> outputs held (op=5, rn=1, rt=0, imm=4), o_ready=0; release -> the next instruction flows with no gap.
- BL with macro: 16'hF000 at pc 0x200, then 16'hF802 -> a single output op=11, rd=14, imm=4, o_pc=0x200. Without the macro: two ILLEGAL outputs.
- BL prefix followed by 16'h2005 -> ILLEGAL with o_pc of the prefix; the following 16'h2005 decodes as MOV_IMM imm=5.
- `i_flush` while WAIT_LO and while o_valid=1 -> o_valid=0 next cycle; a subsequent 16'hF802 is ILLEGAL. `rst`=0 mid-stream -> all outputs return to reset values.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered Thumb halfword decoder with valid/ready on both sides.
// Each accepted halfword becomes one registered output (op, register addresses,
// immediate, condition, pc) one cycle later. Define DECODE_BL_EN to assemble the
// two-halfword BL instruction (11110 prefix + 11111 suffix); without it, both
// halves decode on their own as ILLEGAL.
module decode_stage #(
  parameter int IMM_W = 32,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [15:0]      i_ir,
  input  logic [PC_W-1:0]  i_pc,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [3:0]       o_op,
  output logic [3:0]       o_addrrn,
  output logic [3:0]       o_addrrt,
  output logic [3:0]       o_addrrd,
  output logic [IMM_W-1:0] o_imm,
  output logic [3:0]       o_cond,
  output logic [PC_W-1:0]  o_pc
);

  typedef enum logic [3:0] {
    OP_NOP      = 4'd0,
    OP_ADD_IMM3 = 4'd1,
    OP_SUB_SP   = 4'd2,
    OP_MOV_IMM  = 4'd3,
    OP_MOV_REG  = 4'd4,
    OP_LDR_IMM  = 4'd5,
    OP_LDR_LIT  = 4'd6,
    OP_STR_IMM  = 4'd7,
    OP_B        = 4'd8,
    OP_BCOND    = 4'd9,
    OP_CMP_IMM  = 4'd10,
    OP_BL       = 4'd11,
    OP_ILLEGAL  = 4'd15
  } op_e;

  logic             accept;
  op_e              n_op;
  logic [3:0]       n_rn, n_rt, n_rd, n_cond;
  logic [IMM_W-1:0] n_imm;
  logic [PC_W-1:0]  n_pc;
  logic             n_emit;

`ifdef DECODE_BL_EN
  typedef enum logic {S_IDLE, S_WAIT_LO} state_e;
  state_e          state;
  logic [10:0]     hi_q;
  logic [PC_W-1:0] pc_q;
  logic            is_prefix;

  assign is_prefix = (i_ir[15:11] == 5'b11110);
`endif

  // Flush blocks acceptance; otherwise accept whenever the output slot frees up.
  assign o_ready = !i_flush && (!o_valid || i_ready);
  assign accept  = i_valid && o_ready;

  // Next output contents for the halfword on i_ir (plus BL assembly when enabled).
  always_comb begin
    // NOTE: every signal gets a default first, so no decode path infers a latch.
    n_op   = OP_ILLEGAL;
    n_rn   = '0;
    n_rt   = '0;
    n_rd   = '0;
    n_imm  = '0;
    n_cond = 4'hE;
    n_pc   = i_pc;
    n_emit = 1'b1;
    casez (i_ir[15:7])
      9'b0001110??: begin
        n_op  = OP_ADD_IMM3;
        n_rn  = {1'b0, i_ir[5:3]};
        n_rd  = {1'b0, i_ir[2:0]};
        n_imm = IMM_W'(i_ir[8:6]);
      end
      9'b101100001: begin
        n_op  = OP_SUB_SP;
        n_rn  = 4'd13;
        n_rd  = 4'd13;
        n_imm = IMM_W'({i_ir[6:0], 2'b00});
      end
      9'b00100????: begin
        n_op  = OP_MOV_IMM;
        n_rd  = {1'b0, i_ir[10:8]};
        n_imm = IMM_W'(i_ir[7:0]);
      end
      9'b01000110?: begin
        n_op = OP_MOV_REG;
        n_rn = i_ir[6:3];
        n_rd = {i_ir[7], i_ir[2:0]};
      end
      9'b01101????: begin
        n_op  = OP_LDR_IMM;
        n_rn  = {1'b0, i_ir[5:3]};
        n_rt  = {1'b0, i_ir[2:0]};
        n_imm = IMM_W'({i_ir[10:6], 2'b00});
      end
      9'b01001????: begin
        n_op  = OP_LDR_LIT;
        n_rn  = 4'd15;
        n_rt  = {1'b0, i_ir[10:8]};
        n_imm = IMM_W'({i_ir[7:0], 2'b00});
      end
      9'b01100????: begin
        n_op  = OP_STR_IMM;
        n_rn  = {1'b0, i_ir[5:3]};
        n_rt  = {1'b0, i_ir[2:0]};
        n_imm = IMM_W'({i_ir[10:6], 2'b00});
      end
      9'b11100????: begin
        n_op  = OP_B;
        n_rn  = 4'd15;
        n_imm = {{(IMM_W-12){i_ir[10]}}, i_ir[10:0], 1'b0};
      end
      9'b1101?????: begin
        // Condition codes 1110/1111 are not valid for B<c>.
        if (i_ir[11:9] != 3'b111) begin
          n_op   = OP_BCOND;
          n_rn   = 4'd15;
          n_cond = i_ir[11:8];
          n_imm  = {{(IMM_W-9){i_ir[7]}}, i_ir[7:0], 1'b0};
        end
      end
      9'b00101????: begin
        n_op  = OP_CMP_IMM;
        n_rn  = {1'b0, i_ir[10:8]};
        n_imm = IMM_W'(i_ir[7:0]);
      end
      default: ;
    endcase

`ifdef DECODE_BL_EN
    if (state == S_WAIT_LO) begin
      // Second half of a BL: either completes it or reports the pair as ILLEGAL;
      // the halfword is consumed either way.
      n_pc   = pc_q;
      n_rn   = '0;
      n_rt   = '0;
      n_cond = 4'hE;
      if (i_ir[15:11] == 5'b11111) begin
        n_op  = OP_BL;
        n_rd  = 4'd14;
        n_imm = {{(IMM_W-23){hi_q[10]}}, hi_q, i_ir[10:0], 1'b0};
      end else begin
        n_op  = OP_ILLEGAL;
        n_rd  = '0;
        n_imm = '0;
      end
    end else if (is_prefix) begin
      n_emit = 1'b0;
    end
`endif
  end

  // Output register and BL state: reset, then flush, then transfer, then drain.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) begin
      o_valid  <= 1'b0;
      o_op     <= OP_NOP;
      o_addrrn <= '0;
      o_addrrt <= '0;
      o_addrrd <= '0;
      o_imm    <= '0;
      o_cond   <= 4'hE;
      o_pc     <= '0;
`ifdef DECODE_BL_EN
      state    <= S_IDLE;
      hi_q     <= '0;
      pc_q     <= '0;
`endif
    end else if (i_flush) begin
      o_valid <= 1'b0;
`ifdef DECODE_BL_EN
      state   <= S_IDLE;
`endif
    end else if (accept) begin
      o_valid <= n_emit;
      if (n_emit) begin
        o_op     <= n_op;
        o_addrrn <= n_rn;
        o_addrrt <= n_rt;
        o_addrrd <= n_rd;
        o_imm    <= n_imm;
        o_cond   <= n_cond;
        o_pc     <= n_pc;
      end
`ifdef DECODE_BL_EN
      if (state == S_IDLE && is_prefix) begin
        state <= S_WAIT_LO;
        hi_q  <= i_ir[10:0];
        pc_q  <= i_pc;
      end else begin
        state <= S_IDLE;
      end
`endif
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
